// File: rtl/uv_wb_arb.sv
// uv_wb_arb: writeback arbiter and long-latency scoreboard.
//
// It merges three result sources into the one register-file write port and
// keeps a busy bit for each register that is waiting on a load or a mul/div
// result. The issue stage uses the busy bits to spot read-after-write hazards.
//
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   alu_wb_vld/idx/data        ALU result; always accepted; highest priority
//   lsu_wb_vld/rdy/idx/data    load return, valid/ready handshake
//   mdu_wb_vld/rdy/idx/data    mul/div return, valid/ready handshake
//   iss_long_vld/idx           long-latency op issued; marks its destination busy
//   ra/rb/rc_idx               register indices being read by issue
//   ra/rb/rc_busy              that register still has a pending long-latency write
//   wr_vld/idx/data            registered register-file write port
module uv_wb_arb #(
  parameter int RF_AW = 5,
  parameter int RF_DP = 2**RF_AW,
  parameter int RF_DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_wb_vld,
  input  logic [RF_AW-1:0] alu_wb_idx,
  input  logic [RF_DW-1:0] alu_wb_data,
  input  logic             lsu_wb_vld,
  output logic             lsu_wb_rdy,
  input  logic [RF_AW-1:0] lsu_wb_idx,
  input  logic [RF_DW-1:0] lsu_wb_data,
  input  logic             mdu_wb_vld,
  output logic             mdu_wb_rdy,
  input  logic [RF_AW-1:0] mdu_wb_idx,
  input  logic [RF_DW-1:0] mdu_wb_data,
  input  logic             iss_long_vld,
  input  logic [RF_AW-1:0] iss_long_idx,
  input  logic [RF_AW-1:0] ra_idx,
  input  logic [RF_AW-1:0] rb_idx,
  input  logic [RF_AW-1:0] rc_idx,
  output logic             ra_busy,
  output logic             rb_busy,
  output logic             rc_busy,
  output logic             wr_vld,
  output logic [RF_AW-1:0] wr_idx,
  output logic [RF_DW-1:0] wr_data
);

  // Round-robin pointer: which long-latency source wins when both request.
  localparam logic RR_LSU = 1'b0;
  localparam logic RR_MDU = 1'b1;

  logic             rr_ptr;
  logic             lsu_win;
  logic             mdu_win;
  logic             sel_vld;
  logic             sel_long;
  logic [RF_AW-1:0] sel_idx;
  logic [RF_DW-1:0] sel_data;
  logic             wr_long;
  logic [RF_DP-1:0] busy;
  logic [RF_DP-1:0] busy_nxt;

  // The ALU cannot be stalled, so it blocks both handshaked sources. Between
  // LSU and MDU a lone requester always wins; a tie goes to the pointer.
  assign lsu_win = lsu_wb_vld && !alu_wb_vld && (!mdu_wb_vld || (rr_ptr == RR_LSU));
  assign mdu_win = mdu_wb_vld && !alu_wb_vld && (!lsu_wb_vld || (rr_ptr == RR_MDU));

  assign lsu_wb_rdy = lsu_win;
  assign mdu_wb_rdy = mdu_win;

  // Choose this cycle's write. sel_long remembers whether it came from a
  // long-latency source, since only those writes retire a busy bit.
  always_comb begin
    sel_vld  = 1'b0;
    sel_long = 1'b0;
    sel_idx  = '0;
    sel_data = '0;
    if (alu_wb_vld) begin
      sel_vld  = 1'b1;
      sel_idx  = alu_wb_idx;
      sel_data = alu_wb_data;
    end else if (lsu_win) begin
      sel_vld  = 1'b1;
      sel_long = 1'b1;
      sel_idx  = lsu_wb_idx;
      sel_data = lsu_wb_data;
    end else if (mdu_win) begin
      sel_vld  = 1'b1;
      sel_long = 1'b1;
      sel_idx  = mdu_wb_idx;
      sel_data = mdu_wb_data;
    end
  end

  // After an accepted LSU or MDU transfer, the pointer moves to the other
  // source so that neither can starve the other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= RR_LSU;
    end else if (lsu_win) begin
      rr_ptr <= RR_MDU;
    end else if (mdu_win) begin
      rr_ptr <= RR_LSU;
    end
  end

  // Writes to x0 are accepted and then dropped. wr_idx/wr_data update only on
  // a real write and hold their last values otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld  <= 1'b0;
      wr_long <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
    end else begin
      wr_vld  <= sel_vld && (sel_idx != '0);
      wr_long <= sel_long;
      if (sel_vld && (sel_idx != '0)) begin
        wr_idx  <= sel_idx;
        wr_data <= sel_data;
      end
    end
  end

  // Scoreboard next state. The clear happens on the same edge at which the
  // register file commits the data. A new issue to the same index wins over
  // the clear because it belongs to a younger instruction. Bit 0 stays zero.
  always_comb begin
    busy_nxt = busy;
    if (wr_vld && wr_long) begin
      busy_nxt[wr_idx] = 1'b0;
    end
    if (iss_long_vld && (iss_long_idx != '0)) begin
      busy_nxt[iss_long_idx] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign ra_busy = busy[ra_idx];
  assign rb_busy = busy[rb_idx];
  assign rc_busy = busy[rc_idx];

endmodule

// File: doc/uv_wb_arb.md
Name: uv_wb_arb

Overview:
- Writeback arbiter and long-latency scoreboard that sits directly upstream of the register file.
- Merges three result sources into the single register-file write port (wr_vld/wr_idx/wr_data):
  - ALU: single-cycle, no backpressure.
  - LSU: load return, valid/ready.
  - MDU: mul/div return, valid/ready.
- Tracks destination registers of in-flight loads and mul/div ops, and reports read-after-write hazards for the three register-file read indices back to issue.

Parameters:
- RF_AW, 5, register index width.
- RF_DP, 2**RF_AW, number of architectural registers.
- RF_DW, 32, register data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- alu_wb_vld  in  1  ALU result valid; always accepted.
- alu_wb_idx  in  RF_AW  ALU destination index.
- alu_wb_data  in  RF_DW  ALU result.
- lsu_wb_vld  in  1  load result valid.
- lsu_wb_rdy  out  1  load result accepted this cycle.
- lsu_wb_idx  in  RF_AW  load destination index.
- lsu_wb_data  in  RF_DW  load data.
- mdu_wb_vld  in  1  mul/div result valid.
- mdu_wb_rdy  out  1  mul/div result accepted this cycle.
- mdu_wb_idx  in  RF_AW  mul/div destination index.
- mdu_wb_data  in  RF_DW  mul/div result.
- iss_long_vld  in  1  long-latency op issued this cycle.
- iss_long_idx  in  RF_AW  its destination index.
- ra_idx, rb_idx, rc_idx  in  RF_AW each  read indices being issued.
- ra_busy, rb_busy, rc_busy  out  1 each  index has a pending long-latency write.
- wr_vld  out  1  register-file write enable.
- wr_idx  out  RF_AW  register-file write index.
- wr_data  out  RF_DW  register-file write data.

Behaviour:
- Reset and clock:
  - Reset rst_n, asynchronous, active-low; clock clk.
  - Reset values: wr_vld=0, wr_idx=0, wr_data=0, all busy bits=0, round-robin pointer=LSU.
  - lsu_wb_rdy and mdu_wb_rdy are combinational; their values follow from the inputs after reset.
- Arbitration, combinational, per cycle:
  - ALU has absolute priority. With alu_wb_vld=1, lsu_wb_rdy=mdu_wb_rdy=0.
  - Otherwise, if only one of LSU/MDU is valid, it gets rdy=1.
  - If both are valid, the round-robin pointer selects the winner. The pointer flips to the other source after each accepted LSU/MDU transfer.
  - rdy may depend combinationally on vld; vld must not depend on rdy.
  - Once a source raises vld, it holds vld/idx/data stable until rdy=1. The bench checks this.
- Write stage:
  - One registered stage. The winner's idx/data are captured at the clock edge; wr_* are valid in the next cycle, giving 1-cycle latency from acceptance to wr_vld.
  - Idle cycle gives wr_vld=0. wr_idx/wr_data hold their last values.
  - Destination index 0:
    - The source is still accepted (rdy=1).
    - wr_vld stays 0.
    - No busy bit is touched.
- Scoreboard (busy[RF_DP-1:1], busy[0] hard-wired 0):
  - Set: iss_long_vld=1 and iss_long_idx!=0 sets busy[iss_long_idx] at the clock edge.
  - Clear: busy[wr_idx] is cleared at the edge where wr_vld=1 and the registered write originated from LSU/MDU (internal tag wr_long). This edge is the same one at which the register file commits the data, so no bypass is needed.
  - Set and clear of the same index in one cycle: set wins, because the new issue supersedes.
  - ra/rb/rc_busy = busy[index], combinational. Index 0 always reads 0.
  - ALU writes never clear busy bits. An ALU write to a busy index (WAW) is illegal; issue prevents it, and the bench asserts it never occurs.
- Reset mid-operation: the pipeline register and scoreboard clear immediately. Any in-flight LSU/MDU results are the sources' responsibility to drop.

Test Plan:
- ALU only: alu_wb_vld=1, idx=3, data=0x1234_5678 -> next cycle wr_vld=1, wr_idx=3, wr_data=0x1234_5678; lsu/mdu rdy=0 throughout.
- Scoreboard round-trip:
  - Stimulus: iss_long idx=7; load returns idx=7, data=0xDEAD_BEEF three cycles later.
  - Response: rb_idx=7 gives rb_busy=1 from the edge after issue until the edge where wr_vld=1, wr_idx=7; 0 in the following cycle.
- Contention: LSU (idx=4) and MDU (idx=5) both valid, ALU idle, after reset -> LSU accepted first, MDU next cycle; writes to 4 then 5 on consecutive cycles; pointer back at LSU.
- ALU stall: ALU valid for 3 cycles while LSU holds vld with idx=9 -> lsu_wb_rdy=0 for those 3 cycles, 1 in cycle 4; data stable, single write to x9.
- Boundaries:
  - ALU idx=0 -> wr_vld stays 0.
  - iss_long idx=0 -> ra_busy with ra_idx=0 stays 0.
  - Issue idx=12 in the same cycle as the clearing write to 12 -> busy[12] remains 1.
- Reset: assert rst_n=0 while busy[2]=1 and wr_vld=1 -> wr_vld=0 and all busy outputs=0 immediately, without waiting for a clock edge.
